alu_sequencer: RTL

Microcoded control sequencer for the 8-bit accumulator datapath: it steps T-states, decodes the 4-bit opcode held in the instruction register, and drives the bus-enable, register-load and ALU controls (`sumout`, `sub`, `flagsin`) that make the ALU, accumulator, B register, memory and program counter execute one instruction at a time. It sits between the instruction register / flag outputs and every control pin of the datapath, and it is the only block that asserts ALU controls.

---
 rtl/alu_sequencer_if.sv | 41 ++++
 rtl/alu_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Control interface between the sequencer and the accumulator datapath.
// The master side (instruction register / flags) drives run, opcode and flags;
// the slave side (the sequencer) drives every datapath control pin.
interface alu_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       cf;
  logic       zf;
  logic       pc_out;
  logic       pc_inc;
  logic       jump;
  logic       mar_in;
  logic       ram_out;
  logic       ram_in;
  logic       ir_in;
  logic       ir_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       out_in;
  logic       sumout;
  logic       sub;
  logic       flagsin;
  logic [2:0] tstate;
  logic       instr_done;
  logic       halted;

  modport master (
    output run, opcode, cf, zf,
    input  pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out,
    input  a_in, a_out, b_in, out_in, sumout, sub, flagsin,
    input  tstate, instr_done, halted
  );

  modport slave (
    input  run, opcode, cf, zf,
    output pc_out, pc_inc, jump, mar_in, ram_out, ram_in, ir_in, ir_out,
    output a_in, a_out, b_in, out_in, sumout, sub, flagsin,
    output tstate, instr_done, halted
  );
endinterface

// File: rtl/alu_sequencer.sv
// Microcoded T-state sequencer for the 8-bit accumulator datapath.
// State is only the T-state; every control is a combinational decode of
// the T-state, opcode and ALU flags, so reset clears all controls at once.
module alu_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StT5   = 3'd5,
    StT6   = 3'd6,
    StHalt = 3'd7
  } state_e;

  state_e r_state;
  state_e w_next;

  logic w_pc_out, w_pc_inc, w_jump, w_mar_in, w_ram_out, w_ram_in, w_ir_in;
  logic w_ir_out, w_a_in, w_a_out, w_b_in, w_out_in, w_sumout, w_sub, w_flagsin;
  logic w_done;
  logic w_short;

  // Opcodes that finish after the fetch: NOP and the undefined 9..D.
  always_comb begin
    w_short = 1'b0;
    case (bus.opcode)
      4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: w_short = 1'b1;
      default:                           w_short = 1'b0;
    endcase
  end

  // Microcode decode and next-state selection.
  always_comb begin
    w_pc_out  = 1'b0;
    w_pc_inc  = 1'b0;
    w_jump    = 1'b0;
    w_mar_in  = 1'b0;
    w_ram_out = 1'b0;
    w_ram_in  = 1'b0;
    w_ir_in   = 1'b0;
    w_ir_out  = 1'b0;
    w_a_in    = 1'b0;
    w_a_out   = 1'b0;
    w_b_in    = 1'b0;
    w_out_in  = 1'b0;
    w_sumout  = 1'b0;
    w_sub     = 1'b0;
    w_flagsin = 1'b0;
    w_done    = 1'b0;
    w_next    = r_state;

    unique case (r_state)
      StIdle: begin
        if (bus.run) w_next = StT1;
      end
      StT1: begin
        w_pc_out = 1'b1;
        w_mar_in = 1'b1;
        w_next   = StT2;
      end
      StT2: begin
        w_ram_out = 1'b1;
        w_ir_in   = 1'b1;
        w_pc_inc  = 1'b1;
        if (w_short) w_done = 1'b1;
        else         w_next = StT3;
      end
      StT3: begin
        case (bus.opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            w_ir_out = 1'b1;
            w_mar_in = 1'b1;
            w_next   = StT4;
          end
          4'h5: begin
            w_ir_out = 1'b1;
            w_a_in   = 1'b1;
            w_done   = 1'b1;
          end
          4'h6: begin
            w_ir_out = 1'b1;
            w_jump   = 1'b1;
            w_done   = 1'b1;
          end
          4'h7: begin
            w_ir_out = 1'b1;
            w_jump   = bus.cf;
            w_done   = 1'b1;
          end
          4'h8: begin
            w_ir_out = 1'b1;
            w_jump   = bus.zf;
            w_done   = 1'b1;
          end
          4'hE: begin
            w_a_out  = 1'b1;
            w_out_in = 1'b1;
            w_done   = 1'b1;
          end
          default: w_done = 1'b1;  // HLT, or a short opcode changed after T2
        endcase
      end
      StT4: begin
        case (bus.opcode)
          4'h1: begin
            w_ram_out = 1'b1;
            w_a_in    = 1'b1;
            w_done    = 1'b1;
          end
          4'h2, 4'h3: begin
            w_ram_out = 1'b1;
            w_b_in    = 1'b1;
            w_sub     = (bus.opcode == 4'h3);
            w_next    = StT5;
          end
          4'h4: begin
            w_a_out  = 1'b1;
            w_ram_in = 1'b1;
            w_done   = 1'b1;
          end
          default: w_done = 1'b1;
        endcase
      end
      StT5: begin
        if (bus.opcode == 4'h2 || bus.opcode == 4'h3) begin
          w_sumout  = 1'b1;
          w_a_in    = 1'b1;
          w_flagsin = 1'b1;
          w_sub     = (bus.opcode == 4'h3);
        end
        w_done = 1'b1;
      end
      StT6: begin
        w_next = StT1;  // reserved step, recover by refetching
      end
      StHalt: begin
        w_next = StHalt;
      end
    endcase

    if (w_done) begin
      if (r_state == StT3 && bus.opcode == 4'hF) w_next = StHalt;
      else if (bus.run)                          w_next = StT1;
      else                                       w_next = StIdle;
    end
  end

  // T-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_next;
  end

  // Drive the interface.
  always_comb begin
    bus.pc_out     = w_pc_out;
    bus.pc_inc     = w_pc_inc;
    bus.jump       = w_jump;
    bus.mar_in     = w_mar_in;
    bus.ram_out    = w_ram_out;
    bus.ram_in     = w_ram_in;
    bus.ir_in      = w_ir_in;
    bus.ir_out     = w_ir_out;
    bus.a_in       = w_a_in;
    bus.a_out      = w_a_out;
    bus.b_in       = w_b_in;
    bus.out_in     = w_out_in;
    bus.sumout     = w_sumout;
    bus.sub        = w_sub;
    bus.flagsin    = w_flagsin;
    bus.tstate     = r_state;
    bus.instr_done = w_done;
    bus.halted     = (r_state == StHalt);
  end

endmodule
